axi_lite_from_mem_arb: RTL
==========================

// Module: axi_lite_from_mem_arb
// PURPOSE
// Multi-port successor of the single-port mem-to-AXI-Lite bridge. NumPorts
// independent req/gnt memory ports share one AXI4-Lite master through a
// round-robin arbiter. Up to MaxRequests transactions can be outstanding. Each
// response is routed back to the port that issued it, in global issue order.
// Sits between core-side memory masters (e.g. I$/D$/DMA) and the peripheral
// AXI-Lite crossbar.
// PARAMETERS
// NumPorts      2        number of memory request ports (>=1)
// MemAddrWidth  32       memory-side address width
// AxiAddrWidth  32       AXI address width; zero-extend or truncate mem address
// DataWidth     32       data width (multiple of 8); strobe width DataWidth/8
// MaxRequests   4        outstanding-transaction limit (>=1), depth of order FIFO
// AxiProt       3'b000   constant driven on aw_prot_o/ar_prot_o
// PORTS
// clk_i            in   1                        clock
// rst_ni           in   1                        asynchronous reset, active-low
// mem_req_i        in   NumPorts                 per-port request, held until gnt
// mem_addr_i       in   NumPorts*MemAddrWidth    per-port address, port p in slice p
// mem_we_i         in   NumPorts                 1=write, 0=read
// mem_wdata_i      in   NumPorts*DataWidth       per-port write data
// mem_be_i         in   NumPorts*DataWidth/8     per-port byte enables
// mem_gnt_o        out  NumPorts                 one-hot grant (at most one bit set)
// mem_rsp_valid_o  out  NumPorts                 one-hot response strobe
// mem_rsp_rdata_o  out  DataWidth                r_data_i, broadcast to all ports
// mem_rsp_error_o  out  1                        SLVERR/DECERR on the current response
// outstanding_o    out  $clog2(MaxRequests+1)    in-flight transaction count
// aw_addr_o/aw_prot_o/aw_valid_o out, aw_ready_i in    AXI-Lite AW
// w_data_o/w_strb_o/w_valid_o    out, w_ready_i  in    AXI-Lite W
// b_resp_i/b_valid_i in, b_ready_o out                 AXI-Lite B
// ar_addr_o/ar_prot_o/ar_valid_o out, ar_ready_i in    AXI-Lite AR
// r_data_i/r_resp_i/r_valid_i in, r_ready_o out        AXI-Lite R
// BEHAVIOUR
// - Reset: all valid/ready/gnt/rsp_valid outputs 0, outstanding_o=0,
//   RR pointer=0, lock clear, aw_sent/w_sent clear, order FIFO empty.
//   Reset mid-transfer abandons in-flight transactions.
// - Arbitration: if unlocked, pick the first requesting port at or after the
//   RR pointer (wraps NumPorts-1 -> 0). After a grant to port k, pointer = k+1 mod NumPorts.
// - Lock: once any AXI valid is raised for port k without completing, sel_q=k
//   is locked until mem_gnt_o[k]. AXI valids and payloads stay stable until
//   their handshake.
// - Issue gating: no valid raised and no grant while count==MaxRequests.
//   A pop in the same cycle does not unblock issue.
// - Read: ar_valid_o=1 for the selected read. mem_gnt_o[k]=ar_ready_i in the same cycle.
// - Write: AW and W raised together and may complete in different cycles.
//   aw_sent/w_sent flags record the half already accepted; a sent channel
//   deasserts its valid. Grant in the cycle the second half completes, or
//   when both complete together.
// - On grant, push {we,k} into the order FIFO (not fall-through). The response
//   is therefore no earlier than the cycle after the grant.
// - Response: only the FIFO head channel is readied.
//   r_ready_o = !empty & !head.we; b_ready_o = !empty & head.we.
//   The other channel waits even if valid.
// - On R or B handshake: mem_rsp_valid_o[head.port]=1 and pop the FIFO.
//   mem_rsp_error_o = (resp==2'b10 | resp==2'b11) of the head channel.
//   mem_rsp_rdata_o = r_data_i regardless of channel.
// - Push and pop in the same cycle leave the count unchanged.
//   outstanding_o = FIFO usage.
// - Zero-latency: all AXI ready inputs feed mem_gnt_o combinationally.
//   No registered output stage.
// TESTING
// - Single read from port 0 at 0x1000, ar_ready=1 same cycle
//   -> gnt[0] that cycle; R 0xDEADBEEF OKAY next cycle -> rsp_valid[0], rdata 0xDEADBEEF, error 0.
// - Port1 write, aw_ready in cycle 0, w_ready in cycle 3
//   -> aw_valid drops in cycle 1, w_valid held, gnt[1] only in cycle 3. B SLVERR -> rsp_valid[1], error=1.
// - Ports 0 and 1 both request reads continuously with ar_ready=1
//   -> grants alternate 0,1,0,1; FIFO order matches; responses routed to the matching ports.
// - MaxRequests=4, R stalled -> 4 grants, 5th request sees no ar_valid and no gnt, outstanding_o=4.
//   One R response -> issue resumes the next cycle.
// - Write then read issued, B and R valid in the same cycle
//   -> only b_ready=1 in cycle n; r_ready=1 in n+1; rsp strobes in order.
// - rst_ni low while AW accepted and W pending -> all outputs 0.
//   After release, a new write re-sends both AW and W.

Source files
------------

// File: rtl/axi_lite_from_mem_arb.sv
// Shares one AXI4-Lite master among NumPorts req/gnt memory ports with a
// round-robin arbiter; responses return to the issuing port in issue order.
module axi_lite_from_mem_arb #(
   parameter int unsigned NumPorts     = 2,
   parameter int unsigned MemAddrWidth = 32,
   parameter int unsigned AxiAddrWidth = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned MaxRequests  = 4,
   parameter logic [2:0]  AxiProt      = 3'b000,
   localparam int unsigned StrbWidth   = DataWidth / 8,
   localparam int unsigned CntWidth    = $clog2(MaxRequests + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   // memory ports
   input  logic [NumPorts-1:0]              mem_req_i,
   input  logic [NumPorts*MemAddrWidth-1:0] mem_addr_i,
   input  logic [NumPorts-1:0]              mem_we_i,
   input  logic [NumPorts*DataWidth-1:0]    mem_wdata_i,
   input  logic [NumPorts*StrbWidth-1:0]    mem_be_i,
   output logic [NumPorts-1:0]              mem_gnt_o,
   output logic [NumPorts-1:0]              mem_rsp_valid_o,
   output logic [DataWidth-1:0]             mem_rsp_rdata_o,
   output logic                             mem_rsp_error_o,
   output logic [CntWidth-1:0]              outstanding_o,
   // AXI-Lite AW
   output logic [AxiAddrWidth-1:0]          aw_addr_o,
   output logic [2:0]                       aw_prot_o,
   output logic                             aw_valid_o,
   input  logic                             aw_ready_i,
   // AXI-Lite W
   output logic [DataWidth-1:0]             w_data_o,
   output logic [StrbWidth-1:0]             w_strb_o,
   output logic                             w_valid_o,
   input  logic                             w_ready_i,
   // AXI-Lite B
   input  logic [1:0]                       b_resp_i,
   input  logic                             b_valid_i,
   output logic                             b_ready_o,
   // AXI-Lite AR
   output logic [AxiAddrWidth-1:0]          ar_addr_o,
   output logic [2:0]                       ar_prot_o,
   output logic                             ar_valid_o,
   input  logic                             ar_ready_i,
   // AXI-Lite R
   input  logic [DataWidth-1:0]             r_data_i,
   input  logic [1:0]                       r_resp_i,
   input  logic                             r_valid_i,
   output logic                             r_ready_o
);

   localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned PtrW  = (MaxRequests > 1) ? $clog2(MaxRequests) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   typedef struct packed {
      logic             we;
      logic [PortW-1:0] port;
   } order_t;

   state_t              r_state, w_state_nxt;
   logic [PortW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
   logic [PortW-1:0]    r_sel, w_sel_nxt;
   logic                r_aw_sent, w_aw_sent_nxt;
   logic                r_w_sent, w_w_sent_nxt;

   order_t              r_fifo [MaxRequests];
   logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CntWidth-1:0] r_count;

   logic [MemAddrWidth-1:0] w_addr_arr  [NumPorts];
   logic [DataWidth-1:0]    w_wdata_arr [NumPorts];
   logic [StrbWidth-1:0]    w_be_arr    [NumPorts];

   logic [PortW-1:0] w_arb_sel, w_idx, w_sel;
   logic             w_arb_found, w_sel_req, w_sel_we;
   logic             w_full, w_empty, w_issue;
   logic             w_aw_done, w_w_done, w_fire;
   logic             w_push, w_pop;
   order_t           w_head, w_push_entry;

   for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
      assign w_addr_arr[p]  = mem_addr_i[p*MemAddrWidth +: MemAddrWidth];
      assign w_wdata_arr[p] = mem_wdata_i[p*DataWidth +: DataWidth];
      assign w_be_arr[p]    = mem_be_i[p*StrbWidth +: StrbWidth];
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(MaxRequests - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   // Round-robin search: first requester at or after the pointer.
   always_comb begin
      w_arb_sel   = r_rr_ptr;
      w_arb_found = 1'b0;
      w_idx       = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         w_idx = PortW'((32'(r_rr_ptr) + i) % NumPorts);
         if (!w_arb_found && mem_req_i[w_idx]) begin
            w_arb_found = 1'b1;
            w_arb_sel   = w_idx;
         end
      end
   end

   assign w_sel     = (r_state == ST_LOCKED) ? r_sel : w_arb_sel;
   assign w_sel_req = (r_state == ST_LOCKED) ? mem_req_i[r_sel] : w_arb_found;
   assign w_sel_we  = mem_we_i[w_sel];
   assign w_full    = (r_count == CntWidth'(MaxRequests));
   assign w_empty   = (r_count == '0);
   assign w_issue   = rst_ni & w_sel_req & ~w_full;

   assign ar_valid_o = w_issue & ~w_sel_we;
   assign aw_valid_o = w_issue & w_sel_we & ~r_aw_sent;
   assign w_valid_o  = w_issue & w_sel_we & ~r_w_sent;

   assign ar_addr_o = AxiAddrWidth'(w_addr_arr[w_sel]);
   assign aw_addr_o = AxiAddrWidth'(w_addr_arr[w_sel]);
   assign w_data_o  = w_wdata_arr[w_sel];
   assign w_strb_o  = w_be_arr[w_sel];
   assign ar_prot_o = AxiProt;
   assign aw_prot_o = AxiProt;

   // A write completes once both halves have been accepted, in any order.
   assign w_aw_done = r_aw_sent | (aw_valid_o & aw_ready_i);
   assign w_w_done  = r_w_sent  | (w_valid_o & w_ready_i);
   assign w_fire    = w_sel_we ? (w_issue & w_aw_done & w_w_done)
                               : (ar_valid_o & ar_ready_i);

   always_comb begin
      mem_gnt_o = '0;
      if (w_fire) mem_gnt_o[w_sel] = 1'b1;
   end

   // Issue-side next state: lock the selection while a transfer is half done.
   always_comb begin
      w_state_nxt   = r_state;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_sel_nxt     = r_sel;
      w_aw_sent_nxt = r_aw_sent;
      w_w_sent_nxt  = r_w_sent;
      if (w_fire) begin
         w_state_nxt   = ST_IDLE;
         w_rr_ptr_nxt  = (w_sel == PortW'(NumPorts - 1)) ? '0 : w_sel + PortW'(1);
         w_aw_sent_nxt = 1'b0;
         w_w_sent_nxt  = 1'b0;
      end else if (w_issue) begin
         w_state_nxt   = ST_LOCKED;
         w_sel_nxt     = w_sel;
         w_aw_sent_nxt = w_aw_done;
         w_w_sent_nxt  = w_w_done;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= '0;
         r_sel     <= '0;
         r_aw_sent <= 1'b0;
         r_w_sent  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_sel     <= w_sel_nxt;
         r_aw_sent <= w_aw_sent_nxt;
         r_w_sent  <= w_w_sent_nxt;
      end
   end

   // Order FIFO: only the head's channel is readied so responses stay in issue order.
   assign w_head       = r_fifo[r_rd_ptr];
   assign w_push       = w_fire;
   assign w_push_entry = '{we: w_sel_we, port: w_sel};
   assign r_ready_o    = ~w_empty & ~w_head.we;
   assign b_ready_o    = ~w_empty &  w_head.we;
   assign w_pop        = (r_ready_o & r_valid_i) | (b_ready_o & b_valid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CntWidth'(w_push) - CntWidth'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_push_entry;
   end

   always_comb begin
      mem_rsp_valid_o = '0;
      if (w_pop) mem_rsp_valid_o[w_head.port] = 1'b1;
   end

   assign mem_rsp_error_o = w_pop & (w_head.we ? ((b_resp_i == 2'b10) || (b_resp_i == 2'b11))
                                               : ((r_resp_i == 2'b10) || (r_resp_i == 2'b11)));
   assign mem_rsp_rdata_o = r_data_i;
   assign outstanding_o   = r_count;

endmodule
